// File: rtl/fp_mul_pkg.sv
// Shared definitions for the iterative floating-point multiplier.
//   state_t    : controller states
//   bias_of    : exponent bias for a given exponent width
//   ndig_of    : radix-4 Booth digit count for a given stored-mantissa width
//   canon_nan  : canonical quiet NaN pattern (zero-extended to 64 bits)
package fp_mul_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_NORM = 2'd2,
      S_DONE = 2'd3
   } state_t;

   function automatic int bias_of(input int exp_w);
      return (1 << (exp_w - 1)) - 1;
   endfunction

   // Multiplier operand is {0,1,man}: MAN_W+2 bits, two bits per digit.
   function automatic int ndig_of(input int man_w);
      return (man_w + 3) / 2;
   endfunction

   // {sign=0, exponent all ones, mantissa MSB only}
   function automatic logic [63:0] canon_nan(input int exp_w, input int man_w);
      logic [63:0] v;
      v = ((64'd1 << exp_w) - 64'd1) << man_w;
      v = v | (64'd1 << (man_w - 1));
      return v;
   endfunction

   localparam logic [31:0] CANON_NAN_SP = 32'h7FC0_0000;

endpackage

// File: rtl/booth_r4_enc.sv
// Radix-4 Booth partial-product selector.
//   i_digit : overlapping multiplier bits {b[2i+1], b[2i], b[2i-1]}
//   i_a     : unsigned multiplicand, MSB must be zero so 2A cannot overflow
//   o_pp    : signed partial product in {0, +A, +2A, -A, -2A}
module booth_r4_enc #(
   parameter int A_W = 25
) (
   input  logic [2:0]          i_digit,
   input  logic [A_W-1:0]      i_a,
   output logic signed [A_W:0] o_pp
);

   logic signed [A_W:0] w_a1;
   logic signed [A_W:0] w_a2;

   assign w_a1 = {1'b0, i_a};
   assign w_a2 = {i_a, 1'b0};

   always_comb begin
      o_pp = '0;
      case (i_digit)
         3'b001, 3'b010: o_pp = w_a1;
         3'b011:         o_pp = w_a2;
         3'b100:         o_pp = -w_a2;
         3'b101, 3'b110: o_pp = -w_a1;
         default:        o_pp = '0;
      endcase
   end

endmodule

// File: rtl/iter_fp_mul.sv
// Iterative IEEE-style floating-point multiplier, one Booth digit per cycle,
// truncating, with optional exponent-dependent mantissa precision reduction.
//   clk, rst_n          : clock, async active-low reset
//   in_valid / in_ready : operand handshake (a, b, approx_en sampled on accept)
//   out_valid/out_ready : result handshake (result, ovf, unf held until taken)
//
// state  | meaning
// IDLE   | waiting for operands, in_ready high
// MUL    | accumulating one Booth partial product per cycle
// NORM   | phase 0: normalise product; phase 1: pack result and flags
// DONE   | result presented, waiting for out_ready
module iter_fp_mul
   import fp_mul_pkg::*;
#(
   parameter int EXP_W     = 8,
   parameter int MAN_W     = 23,
   parameter int TRUNC_MAX = 14
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [EXP_W+MAN_W:0] a,
   input  logic [EXP_W+MAN_W:0] b,
   input  logic                 approx_en,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [EXP_W+MAN_W:0] result,
   output logic                 ovf,
   output logic                 unf
);

   localparam int W    = 1 + EXP_W + MAN_W;
   localparam int BIAS = bias_of(EXP_W);
   localparam int NDIG = ndig_of(MAN_W);
   localparam int A_W  = MAN_W + 2;
   localparam int MB_W = 2 * NDIG + 1;
   localparam int PW   = 2 * MAN_W + 2;
   localparam int EW   = EXP_W + 2;
   localparam int CW   = $clog2(NDIG + 1);
   localparam logic [W-1:0]         NAN_VAL = W'(canon_nan(EXP_W, MAN_W));
   localparam logic signed [EW-1:0] EXP_MAX = EW'((1 << EXP_W) - 1);

   function automatic logic f_exp_special(input logic [EXP_W-1:0] e);
      return (e == '0) || (e == '1);
   endfunction

   state_t                r_state;
   state_t                w_state_nxt;
   logic [W-1:0]          r_a;
   logic [W-1:0]          r_b;
   logic                  r_approx;
   logic [MB_W-1:0]       r_mb_sh;
   logic [PW-1:0]         r_acc;
   logic [CW-1:0]         r_cnt;
   logic                  r_norm_ph;
   logic signed [EW-1:0]  r_exp;
   logic signed [EW-1:0]  r_exp_n;
   logic [MAN_W-1:0]      r_man;
   logic [W-1:0]          r_result;
   logic                  r_ovf;
   logic                  r_unf;

   logic                  w_s;
   logic [EXP_W-1:0]      w_ea, w_eb;
   logic [MAN_W-1:0]      w_ma, w_mb;
   logic                  w_a_zero, w_b_zero, w_a_inf, w_b_inf, w_a_nan, w_b_nan;
   logic                  w_in_special;
   logic signed [EW-1:0]  w_exp_sum;
   logic signed [A_W:0]   w_pp;
   logic [PW-1:0]         w_pp_ext;
   logic [CW:0]           w_shamt;
   logic [PW-1:0]         w_pp_sh;
   logic [EW-1:0]         w_dev;
   logic [EW-1:0]         w_abs;
   logic [EW-1:0]         w_sh;
   logic [2:0]            w_lvl;
   logic [4:0]            w_t_raw;
   logic [4:0]            w_t;
   logic [MAN_W-1:0]      w_man_q;
   logic [W-1:0]          w_res_nxt;
   logic                  w_ovf_nxt;
   logic                  w_unf_nxt;

   assign w_s  = r_a[W-1] ^ r_b[W-1];
   assign w_ea = r_a[W-2 -: EXP_W];
   assign w_eb = r_b[W-2 -: EXP_W];
   assign w_ma = r_a[MAN_W-1:0];
   assign w_mb = r_b[MAN_W-1:0];

   assign w_a_zero = (w_ea == '0);
   assign w_b_zero = (w_eb == '0);
   assign w_a_inf  = (w_ea == '1) && (w_ma == '0);
   assign w_b_inf  = (w_eb == '1) && (w_mb == '0);
   assign w_a_nan  = (w_ea == '1) && (w_ma != '0);
   assign w_b_nan  = (w_eb == '1) && (w_mb != '0);

   assign w_in_special = f_exp_special(a[W-2 -: EXP_W]) || f_exp_special(b[W-2 -: EXP_W]);
   assign w_exp_sum    = {2'b00, a[W-2 -: EXP_W]} + {2'b00, b[W-2 -: EXP_W]} - EW'(BIAS);

   booth_r4_enc #(.A_W(A_W)) u_booth_r4_enc (
      .i_digit (r_mb_sh[2:0]),
      .i_a     ({2'b01, w_ma}),
      .o_pp    (w_pp)
   );

   // The final product is non-negative and fits PW bits, so accumulating
   // modulo 2^PW gives the exact result even when partial sums go negative.
   assign w_pp_ext = {{(PW-A_W-1){w_pp[A_W]}}, w_pp};
   assign w_shamt  = {r_cnt, 1'b0};
   assign w_pp_sh  = w_pp_ext << w_shamt;

   // Precision level follows the pre-normalisation exponent's distance from bias.
   assign w_dev   = r_exp - EW'(BIAS);
   assign w_abs   = w_dev[EW-1] ? (~w_dev + EW'(1)) : w_dev;
   assign w_sh    = w_abs >> (EXP_W - 4);
   assign w_lvl   = (w_sh > EW'(7)) ? 3'd7 : w_sh[2:0];
   assign w_t_raw = {1'b0, 3'd7 - w_lvl, 1'b0};
   assign w_t     = !r_approx ? 5'd0 :
                    (w_t_raw > 5'(TRUNC_MAX)) ? 5'(TRUNC_MAX) : w_t_raw;
   assign w_man_q = r_man & ({MAN_W{1'b1}} << w_t);

   always_comb begin
      w_res_nxt = '0;
      w_ovf_nxt = 1'b0;
      w_unf_nxt = 1'b0;
      if (w_a_nan || w_b_nan || (w_a_inf && w_b_zero) || (w_a_zero && w_b_inf)) begin
         w_res_nxt = NAN_VAL;
      end else if (w_a_inf || w_b_inf) begin
         w_res_nxt = {w_s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      end else if (w_a_zero || w_b_zero) begin
         w_res_nxt = {w_s, {(W-1){1'b0}}};
      end else if (r_exp_n >= EXP_MAX) begin
         w_res_nxt = {w_s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
         w_ovf_nxt = 1'b1;
      end else if (r_exp_n[EW-1] || (r_exp_n == '0)) begin
         w_res_nxt = {w_s, {(W-1){1'b0}}};
         w_unf_nxt = 1'b1;
      end else begin
         w_res_nxt = {w_s, r_exp_n[EXP_W-1:0], w_man_q};
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      in_ready    = 1'b0;
      out_valid   = 1'b0;
      case (r_state)
         S_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) w_state_nxt = w_in_special ? S_NORM : S_MUL;
         end
         S_MUL:  if (r_cnt == CW'(NDIG - 1)) w_state_nxt = S_NORM;
         S_NORM: if (r_norm_ph) w_state_nxt = S_DONE;
         S_DONE: begin
            out_valid = 1'b1;
            if (out_ready) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_a       <= '0;
         r_b       <= '0;
         r_approx  <= 1'b0;
         r_mb_sh   <= '0;
         r_acc     <= '0;
         r_cnt     <= '0;
         r_norm_ph <= 1'b0;
         r_exp     <= '0;
         r_exp_n   <= '0;
         r_man     <= '0;
         r_result  <= '0;
         r_ovf     <= 1'b0;
         r_unf     <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  r_a       <= a;
                  r_b       <= b;
                  r_approx  <= approx_en;
                  r_mb_sh   <= MB_W'({2'b01, b[MAN_W-1:0], 1'b0});
                  r_acc     <= '0;
                  r_cnt     <= '0;
                  r_norm_ph <= 1'b0;
                  r_exp     <= w_exp_sum;
               end
            end
            S_MUL: begin
               r_acc   <= r_acc + w_pp_sh;
               r_mb_sh <= r_mb_sh >> 2;
               r_cnt   <= r_cnt + CW'(1);
            end
            S_NORM: begin
               if (!r_norm_ph) begin
                  r_norm_ph <= 1'b1;
                  if (r_acc[PW-1]) begin
                     r_man   <= r_acc[PW-2 -: MAN_W];
                     r_exp_n <= r_exp + EW'(1);
                  end else begin
                     r_man   <= r_acc[PW-3 -: MAN_W];
                     r_exp_n <= r_exp;
                  end
               end else begin
                  r_result <= w_res_nxt;
                  r_ovf    <= w_ovf_nxt;
                  r_unf    <= w_unf_nxt;
               end
            end
            default: ;
         endcase
      end
   end

   assign result = r_result;
   assign ovf    = r_ovf;
   assign unf    = r_unf;

endmodule

// File: tb/tb_iter_fp_mul.sv
module tb_iter_fp_mul;

   localparam int TRUNC_MAX = 14;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] a;
   logic [31:0] b;
   logic        approx_en;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] result;
   logic        ovf;
   logic        unf;

   int n_tests = 0;
   int n_fail  = 0;

   iter_fp_mul #(.EXP_W(8), .MAN_W(23), .TRUNC_MAX(TRUNC_MAX)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .approx_en (approx_en),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .ovf       (ovf),
      .unf       (unf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: exact integer product of the significands, then the
   // normalise / truncate / precision / range rules applied arithmetically.
   function automatic void ref_mul(input logic [31:0] x, input logic [31:0] y, input logic ap,
                                   output logic [31:0] r, output logic o, output logic u);
      int ex, ey, e, d, t;
      logic s, nx, ny, ix, iy, zx, zy;
      longint unsigned mx, my, p, m;
      s  = x[31] ^ y[31];
      ex = int'(x[30:23]);
      ey = int'(y[30:23]);
      zx = (ex == 0);
      zy = (ey == 0);
      ix = (ex == 255) && (x[22:0] == 23'h0);
      iy = (ey == 255) && (y[22:0] == 23'h0);
      nx = (ex == 255) && (x[22:0] != 23'h0);
      ny = (ey == 255) && (y[22:0] != 23'h0);
      r = 32'h0;
      o = 1'b0;
      u = 1'b0;
      if (nx || ny || (ix && zy) || (zx && iy)) begin
         r = 32'h7FC0_0000;
      end else if (ix || iy) begin
         r = {s, 8'hFF, 23'h0};
      end else if (zx || zy) begin
         r = {s, 31'h0};
      end else begin
         mx = {40'h0, 1'b1, x[22:0]};
         my = {40'h0, 1'b1, y[22:0]};
         p  = mx * my;
         e  = ex + ey - 127;
         d  = e - 127;
         if (d < 0) d = -d;
         d = d / 16;
         if (d > 7) d = 7;
         t = 2 * (7 - d);
         if (t > TRUNC_MAX) t = TRUNC_MAX;
         if (!ap) t = 0;
         if (p >= (64'd1 << 47)) begin
            m = (p >> 24) & 64'h7F_FFFF;
            e = e + 1;
         end else begin
            m = (p >> 23) & 64'h7F_FFFF;
         end
         m = (m >> t) << t;
         if (e >= 255) begin
            r = {s, 8'hFF, 23'h0};
            o = 1'b1;
         end else if (e <= 0) begin
            r = {s, 31'h0};
            u = 1'b1;
         end else begin
            r = {s, 8'(e), 23'(m)};
         end
      end
   endfunction

   function automatic logic [31:0] rand_op();
      logic [31:0] v;
      int k;
      v = $urandom;
      k = $urandom_range(0, 15);
      if (k == 0) v[30:23] = 8'h00;
      else if (k == 1) begin
         v[30:23] = 8'hFF;
         if ($urandom_range(0, 1) == 0) v[22:0] = 23'h0;
      end else if (k < 11) v[30:23] = 8'($urandom_range(90, 165));
      return v;
   endfunction

   // One transaction; junk operands with in_valid high are offered while busy
   // and through the result handover, and must never be taken.
   task automatic do_op(input logic [31:0] xa, input logic [31:0] xb, input logic ap,
                        input logic [31:0] er, input logic eo, input logic eu,
                        input int elat, input int stall, input string tag);
      int lat;
      out_ready = (stall == 0);
      @(negedge clk);
      a = xa;
      b = xb;
      approx_en = ap;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      a = $urandom;
      b = $urandom;
      approx_en = ~ap;
      lat = 0;
      while (out_valid !== 1'b1 && lat < 40) begin
         @(posedge clk);
         #1;
         lat++;
      end
      chk({tag, "/latency"}, 64'(lat), 64'(elat));
      chk({tag, "/result"}, 64'(result), 64'(er));
      chk({tag, "/ovf"}, 64'(ovf), 64'(eo));
      chk({tag, "/unf"}, 64'(unf), 64'(eu));
      for (int i = 0; i < stall; i++) begin
         @(posedge clk);
         #1;
         chk({tag, "/hold_result"}, 64'(result), 64'(er));
         chk({tag, "/hold_valid"}, 64'(out_valid), 64'd1);
         chk({tag, "/hold_in_ready"}, 64'(in_ready), 64'd0);
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      chk({tag, "/idle_in_ready"}, 64'(in_ready), 64'd1);
      chk({tag, "/idle_out_valid"}, 64'(out_valid), 64'd0);
   endtask

   initial begin
      logic [31:0] ra, rb, er;
      logic        ap, eo, eu;
      int          elat;

      rst_n = 1'b1;
      in_valid = 1'b0;
      out_ready = 1'b1;
      approx_en = 1'b0;
      a = 32'h0;
      b = 32'h0;
      #2 rst_n = 1'b0;
      #1;
      chk("reset/out_valid", 64'(out_valid), 64'd0);
      chk("reset/in_ready", 64'(in_ready), 64'd1);
      chk("reset/result", 64'(result), 64'd0);
      chk("reset/ovf", 64'(ovf), 64'd0);
      chk("reset/unf", 64'(unf), 64'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      do_op(32'h3FC0_0000, 32'h4000_0000, 1'b0, 32'h4040_0000, 1'b0, 1'b0, 15, 0, "1p5x2");
      do_op(32'h3F80_0001, 32'h3F80_0001, 1'b0, 32'h3F80_0002, 1'b0, 1'b0, 15, 0, "exact_lsb");
      do_op(32'h3F80_0001, 32'h3F80_0001, 1'b1, 32'h3F80_0000, 1'b0, 1'b0, 15, 0, "approx_lsb");
      do_op(32'h0080_0000, 32'h0080_0000, 1'b0, 32'h0000_0000, 1'b0, 1'b1, 15, 0, "underflow");
      do_op(32'h7F80_0000, 32'h0000_0000, 1'b0, 32'h7FC0_0000, 1'b0, 1'b0, 2, 0, "inf_x_zero");
      do_op(32'h8000_0000, 32'h3F80_0000, 1'b0, 32'h8000_0000, 1'b0, 1'b0, 2, 0, "negzero");
      do_op(32'hFF80_0000, 32'h4000_0000, 1'b0, 32'hFF80_0000, 1'b0, 1'b0, 2, 0, "neginf");
      do_op(32'h7F00_0000, 32'h7F00_0000, 1'b0, 32'h7F80_0000, 1'b1, 1'b0, 15, 5, "overflow_stall");

      // Asynchronous reset in the sixth MUL cycle.
      @(negedge clk);
      a = 32'h3FC0_0000;
      b = 32'h4000_0000;
      approx_en = 1'b0;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (5) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("midreset/out_valid", 64'(out_valid), 64'd0);
      chk("midreset/in_ready", 64'(in_ready), 64'd1);
      chk("midreset/result", 64'(result), 64'd0);
      chk("midreset/ovf", 64'(ovf), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("midreset/in_ready_after", 64'(in_ready), 64'd1);
      chk("midreset/out_valid_after", 64'(out_valid), 64'd0);
      do_op(32'h3FC0_0000, 32'h4000_0000, 1'b0, 32'h4040_0000, 1'b0, 1'b0, 15, 0, "after_reset");

      for (int i = 0; i < 40; i++) begin
         ra = rand_op();
         rb = rand_op();
         ap = 1'($urandom_range(0, 1));
         ref_mul(ra, rb, ap, er, eo, eu);
         elat = ((ra[30:23] == 8'h00) || (ra[30:23] == 8'hFF) ||
                 (rb[30:23] == 8'h00) || (rb[30:23] == 8'hFF)) ? 2 : 15;
         do_op(ra, rb, ap, er, eo, eu, elat, (i % 8 == 3) ? 2 : 0,
               $sformatf("rand%0d_%h_%h_%0d", i, ra, rb, ap));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
